// File: rtl/nexys4_ddr_top.sv
// Nexys4-DDR test datapath: two 8-bit switch operands feed a two-stage
// registered pipeline computing add/xor or multiply; results and a count of
// enabled updates are shown on the LEDs.
module nexys4_ddr_top #(
    parameter int unsigned A_W   = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,   // active-high despite the legacy name
    input  logic        BTNC,
    input  logic        UART_TXD_IN,
    input  logic [31:0] SW,
    output logic [31:0] LED
);

    // Stage-1 operand/control registers
    logic [A_W-1:0]   a_q, b_q;
    logic             en_q, md_q;

    // Stage-2 result and update counter
    logic [2*A_W-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*A_W-1:0] prod;
    logic [A_W-1:0]   sum;

    // Upper switches carry no function on this board build.
    logic unused_sw;
    assign unused_sw = ^SW[31:16];

    // Stage 1: sample switches and controls every cycle
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESETN) begin
            a_q  <= '0;
            b_q  <= '0;
            en_q <= 1'b0;
            md_q <= 1'b0;
        end else begin
            a_q  <= SW[2*A_W-1:A_W];
            b_q  <= SW[A_W-1:0];
            en_q <= BTNC;
            md_q <= UART_TXD_IN;
        end
    end

    // Stage 2 next state: select add/xor or product, bump the counter on update
    always_comb begin
        res_d = res_q;
        cnt_d = cnt_q;
        sum   = a_q + b_q;   // carry out intentionally dropped
        prod  = (2*A_W)'(a_q) * (2*A_W)'(b_q);
        if (en_q) begin
            if (md_q) begin
                res_d = prod;
            end else begin
                res_d = {a_q ^ b_q, sum};
            end
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Stage 2 register: LED is driven only from these flops
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESETN) begin
            res_q <= '0;
            cnt_q <= '0;
        end else begin
            res_q <= res_d;
            cnt_q <= cnt_d;
        end
    end

    assign LED = {cnt_q, res_q};

endmodule

// File: tb/tb_nexys4_ddr_top.sv
// Self-checking bench for nexys4_ddr_top: a behavioural model pushes the
// expected LED value for every clock into a scoreboard queue; each test pops
// and compares after the DUT edge.
module tb_nexys4_ddr_top;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btnc = 1'b0;
    logic        modif = 1'b0;
    logic [31:0] sw = '0;
    logic [31:0] led;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] sb[$];

    // Reference model state: inputs captured at the previous edge plus LEDs
    logic [7:0]  p_a, p_b;
    logic        p_en, p_md;
    logic [31:0] m_led;

    nexys4_ddr_top dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst),
        .BTNC       (btnc),
        .UART_TXD_IN(modif),
        .SW         (sw),
        .LED        (led)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model and queue the expected LED
    task automatic drive(input logic [31:0] s, input logic en, input logic md,
                         input logic r);
        logic [15:0] a16, b16;
        @(negedge clk);
        sw    = s;
        btnc  = en;
        modif = md;
        rst   = r;
        @(posedge clk);
        #1;
        if (r) begin
            m_led = '0;
            p_a = '0; p_b = '0; p_en = 1'b0; p_md = 1'b0;
        end else begin
            if (p_en) begin
                a16 = {8'h00, p_a};
                b16 = {8'h00, p_b};
                if (p_md) m_led[15:0] = a16 * b16;
                else      m_led[15:0] = {p_a ^ p_b, 8'((a16 + b16) & 16'h00ff)};
                m_led[31:16] = m_led[31:16] + 16'd1;
            end
            p_a  = s[15:8];
            p_b  = s[7:0];
            p_en = en;
            p_md = md;
        end
        sb.push_back(m_led);
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        for (int i = 0; i < 2; i++) begin
            drive($urandom, 1'($urandom), 1'($urandom), 1'b1);
            exp = sb.pop_front();
            n_checks++;
            if (led !== 32'h0 || exp !== 32'h0) begin
                n_errors++;
                $display("FAIL reset_hold: LED=%h want 00000000", led);
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive($urandom, 1'b0, 1'($urandom), 1'b0);
            exp = sb.pop_front();
            n_checks++;
            if (led !== 32'h0) begin
                n_errors++;
                $display("FAIL reset_release: LED=%h want 00000000", led);
            end
        end
    endtask

    task automatic test_add();
        logic [31:0] exp;
        drive(32'h0000_0305, 1'b1, 1'b0, 1'b0);
        exp = sb.pop_front();
        n_checks++;
        if (led !== 32'h0) begin
            n_errors++;
            $display("FAIL add_latency: LED=%h want 00000000 after one clock", led);
        end
        drive(32'h0000_0000, 1'b0, 1'b0, 1'b0);
        exp = sb.pop_front();
        n_checks++;
        if (led !== 32'h0001_0608 || led !== exp) begin
            n_errors++;
            $display("FAIL add: LED=%h want 00010608 (model %h)", led, exp);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        drive(32'h0000_ff01, 1'b1, 1'b0, 1'b0);
        exp = sb.pop_front();
        drive(32'h0000_0000, 1'b0, 1'b0, 1'b0);
        exp = sb.pop_front();
        n_checks++;
        if (led !== 32'h0002_fe00 || led !== exp) begin
            n_errors++;
            $display("FAIL add_wrap: LED=%h want 0002fe00 (model %h)", led, exp);
        end
    endtask

    task automatic test_multiply();
        logic [31:0] exp;
        // Back-to-back: two products on consecutive cycles
        drive(32'h0000_1020, 1'b1, 1'b1, 1'b0);
        exp = sb.pop_front();
        drive(32'h0000_ffff, 1'b1, 1'b1, 1'b0);
        exp = sb.pop_front();
        n_checks++;
        if (led !== 32'h0003_0200 || led !== exp) begin
            n_errors++;
            $display("FAIL mul_small: LED=%h want 00030200 (model %h)", led, exp);
        end
        drive(32'h0000_0000, 1'b0, 1'b0, 1'b0);
        exp = sb.pop_front();
        n_checks++;
        if (led !== 32'h0004_fe01 || led !== exp) begin
            n_errors++;
            $display("FAIL mul_max: LED=%h want 0004fe01 (model %h)", led, exp);
        end
    endtask

    task automatic test_hold();
        logic [31:0] held, exp, s;
        held = led;
        s = 32'h0000_1000;
        for (int i = 0; i < 6; i++) begin
            drive(s, 1'b0, 1'($urandom), 1'b0);
            exp = sb.pop_front();
            n_checks++;
            if (led !== held) begin
                n_errors++;
                $display("FAIL hold[%0d]: LED=%h want %h", i, led, held);
            end
            s = s + 32'd2;
        end
        for (int i = 0; i < 6; i++) begin
            drive(s, 1'b1, 1'(i), 1'b0);
            exp = sb.pop_front();
            n_checks++;
            if (led !== exp) begin
                n_errors++;
                $display("FAIL hold_resume[%0d]: LED=%h want %h", i, led, exp);
            end
            s = s + 32'd2;
        end
    endtask

    task automatic test_counter();
        logic [31:0] exp;
        drive($urandom, 1'b0, 1'b0, 1'b1);
        exp = sb.pop_front();
        for (int i = 0; i < 65536; i++) begin
            drive($urandom, 1'b1, 1'($urandom), 1'b0);
            exp = sb.pop_front();
            n_checks++;
            if (led !== exp) begin
                n_errors++;
                $display("FAIL count_run[%0d]: LED=%h want %h", i, led, exp);
            end
        end
        drive($urandom, 1'b0, 1'b0, 1'b0);
        exp = sb.pop_front();
        n_checks++;
        if (led[31:16] !== 16'h0000 || led !== exp) begin
            n_errors++;
            $display("FAIL count_wrap: LED=%h want count 0000 (model %h)", led, exp);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp;
        for (int i = 0; i < 140; i++) begin
            drive($urandom, 1'($urandom), 1'($urandom), 1'b0);
            exp = sb.pop_front();
            n_checks++;
            if (led !== exp) begin
                n_errors++;
                $display("FAIL random[%0d]: LED=%h want %h", i, led, exp);
            end
        end
    endtask

    initial begin
        p_a = '0; p_b = '0; p_en = 1'b0; p_md = 1'b0;
        m_led = '0;
        test_reset();
        test_add();
        test_wrap();
        test_multiply();
        test_hold();
        test_counter();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
